ccx_seq: RTL and testbench
==========================

Name: ccx_seq

Overview:
- Sequences one 32-bit custom-compute (CCX) operation from the core over the narrow off-chip CCX pad interface.
- Latches both operands and the function select, then shifts operands out CHUNKSIZE bits per beat, LSB chunk first.
- Each beat uses a four-phase req/resp handshake; the result chunk is captured on every beat.
- Sits between the core's CCX port and the chip pads; assembles a full result word and reports done or timeout to the core.

Parameters:
- XLEN, 32, operand/result width; must be a multiple of CHUNKSIZE.
- CHUNKSIZE, 4, bits transferred per beat on each bus.
- SYNC_STAGES, 2, flops in the ccx_resp_i synchronizer (min 2).
- TIMEOUT, 64, max cycles spent in REQ or ACK before abort (≥2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  1  core requests operation; sampled only in IDLE
- sel_i  in  2  function select, latched on accept
- rs_a_i  in  XLEN  operand A, latched on accept
- rs_b_i  in  XLEN  operand B, latched on accept
- busy_o  out  1  high from accept until DONE inclusive
- rdy_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse with rdy_o on timeout abort
- res_o  out  XLEN  assembled result; valid when rdy_o=1, held until next accept
- ccx_rs_a_o  out  CHUNKSIZE  current operand A chunk
- ccx_rs_b_o  out  CHUNKSIZE  current operand B chunk
- ccx_sel_o  out  2  latched select, held until next accept
- ccx_req_o  out  1  beat request, registered
- ccx_res_i  in  CHUNKSIZE  result chunk; valid while external resp is high
- ccx_resp_i  in  1  external acknowledge, asynchronous

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs 0; beat counter and timeout counter 0; synchronizer flops 0.
- BEATS = XLEN/CHUNKSIZE (8 at defaults). Beat counter width is clog2(BEATS).
- resp_s is ccx_resp_i after SYNC_STAGES flops. ccx_res_i is sampled only when resp_s=1.
- IDLE:
  - If req_i=1 and resp_s=0: latch rs_a_i, rs_b_i and sel_i; clear res; set busy_o; go to SETUP.
  - If req_i=1 while resp_s=1 (stale ack): stay IDLE, do not accept.
- SETUP (1 cycle): drive ccx_rs_a_o/ccx_rs_b_o with operand chunk[beat]; ccx_req_o=0; go to REQ. This gives the pads one cycle of data setup before the request edge.
- REQ: ccx_req_o=1 and chunks held stable.
  - On resp_s=1: shift ccx_res_i into the res MSB chunk (res >> CHUNKSIZE); go to ACK. After BEATS beats chunk 0 sits in res[CHUNKSIZE-1:0].
- ACK: ccx_req_o=0 and chunks still held.
  - On resp_s=0: if beat=BEATS-1 go to DONE, else beat+1 and go to SETUP.
- DONE (1 cycle): rdy_o=1; res_o updated; busy_o=1 this cycle; go to IDLE. ccx_sel_o and the last chunks stay held.
- Timeout:
  - The counter clears on every entry to REQ or ACK and increments each cycle spent there.
  - After TIMEOUT cycles in the same state: ccx_req_o=0, go to DONE with err_o=1. res_o is then forced to 0.
- req_i while busy: ignored; no queuing.
- Operands and select are latched, so the core may change them after the accept cycle.
- Reset mid-operation: immediate return to IDLE with ccx_req_o=0. The external side must tolerate a dropped request.
- Timing with a registered responder (resp follows req one cycle later) and SYNC_STAGES=2:
  - 9 cycles per beat.
  - With req_i accepted at cycle c, rdy_o is high at cycle c+73.

Decomposition:
- Package ccx_pkg holds the state enum {IDLE, SETUP, REQ, ACK, DONE} and the CCX_SEL_W=2 constant.
- Beat count and timeout width are derived locally from the parameters.
- One natural sub-module, ccx_sync: an N-stage synchronizer with async active-high reset to 0, used for ccx_resp_i.

Test Plan:
1. Registered echo responder (res chunk = rs_a chunk XOR rs_b chunk); rs_a=0x12345678, rs_b=0xFFFF0000, sel=1, req at cycle c -> rdy_o at c+73, err_o=0, res_o=0xEDCB5678, ccx_sel_o=1 throughout.
2. Chunk ordering: rs_a=0x76543210 -> ccx_rs_a_o shows 0,1,…,7 on successive REQ phases; each chunk is stable from SETUP through the end of ACK.
3. Silent responder (resp never rises), TIMEOUT=64 -> REQ spans c+2..c+65, ccx_req_o falls, then rdy_o=err_o=1 at c+66 with res_o=0; busy_o low at c+67.
4. Stale ack: hold ccx_resp_i=1 while idle and pulse req_i -> no accept, busy_o stays 0; release resp -> the next req_i is accepted.
5. Responder with random 0–10 cycle delays; 200 random operand/select pairs -> every res_o matches the model, no err_o, req_i pulses during busy are ignored.
6. Assert rst_i mid-beat 3 -> ccx_req_o, busy_o, rdy_o and the chunk outputs go 0 asynchronously; a following operation completes correctly.

Source files
------------

// File: rtl/ccx_pkg.sv
// Shared types and constants for the CCX pad sequencer.
package ccx_pkg;

  localparam int unsigned CCX_SEL_W = 2;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StReq,
    StAck,
    StDone
  } ccx_state_e;

endpackage

// File: rtl/ccx_sync.sv
// N-stage synchronizer for an asynchronous level input, reset to 0.
module ccx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ccx_seq.sv
// Sequences one CCX operation over the narrow pad bus: operands go out a chunk per
// four-phase beat, LSB chunk first, and result chunks are assembled into a full word.
module ccx_seq
  import ccx_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned CHUNKSIZE   = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic [CCX_SEL_W-1:0] sel_i,
  input  logic [XLEN-1:0]      rs_a_i,
  input  logic [XLEN-1:0]      rs_b_i,
  output logic                 busy_o,
  output logic                 rdy_o,
  output logic                 err_o,
  output logic [XLEN-1:0]      res_o,
  output logic [CHUNKSIZE-1:0] ccx_rs_a_o,
  output logic [CHUNKSIZE-1:0] ccx_rs_b_o,
  output logic [CCX_SEL_W-1:0] ccx_sel_o,
  output logic                 ccx_req_o,
  input  logic [CHUNKSIZE-1:0] ccx_res_i,
  input  logic                 ccx_resp_i
);

  localparam int unsigned BEATS = XLEN / CHUNKSIZE;
  localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);

  localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);
  localparam logic [TmoW-1:0]  LastTmo  = TmoW'(TIMEOUT - 1);

  ccx_state_e      state_q;
  logic [BeatW-1:0] beat_q;
  logic [TmoW-1:0]  tmo_q;
  logic [XLEN-1:0]  op_a_q;
  logic [XLEN-1:0]  op_b_q;
  logic [XLEN-1:0]  res_q;
  logic             resp_s;

  ccx_sync #(
    .STAGES(SYNC_STAGES)
  ) u_resp_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (ccx_resp_i),
    .q_o  (resp_s)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      tmo_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_q      <= '0;
      busy_o     <= 1'b0;
      rdy_o      <= 1'b0;
      err_o      <= 1'b0;
      res_o      <= '0;
      ccx_rs_a_o <= '0;
      ccx_rs_b_o <= '0;
      ccx_sel_o  <= '0;
      ccx_req_o  <= 1'b0;
    end else begin
      rdy_o <= 1'b0;
      err_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A still-high ack from a previous transfer would complete beat 0 instantly.
          if (req_i && !resp_s) begin
            op_a_q     <= rs_a_i;
            op_b_q     <= rs_b_i;
            ccx_sel_o  <= sel_i;
            ccx_rs_a_o <= rs_a_i[CHUNKSIZE-1:0];
            ccx_rs_b_o <= rs_b_i[CHUNKSIZE-1:0];
            res_q      <= '0;
            res_o      <= '0;
            beat_q     <= '0;
            busy_o     <= 1'b1;
            state_q    <= StSetup;
          end
        end
        StSetup: begin
          ccx_req_o <= 1'b1;
          tmo_q     <= '0;
          state_q   <= StReq;
        end
        StReq: begin
          if (resp_s) begin
            res_q     <= {ccx_res_i, res_q[XLEN-1:CHUNKSIZE]};
            ccx_req_o <= 1'b0;
            tmo_q     <= '0;
            state_q   <= StAck;
          end else if (tmo_q == LastTmo) begin
            ccx_req_o <= 1'b0;
            rdy_o     <= 1'b1;
            err_o     <= 1'b1;
            res_o     <= '0;
            state_q   <= StDone;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StAck: begin
          if (!resp_s) begin
            if (beat_q == LastBeat) begin
              rdy_o   <= 1'b1;
              res_o   <= res_q;
              state_q <= StDone;
            end else begin
              beat_q     <= beat_q + 1'b1;
              op_a_q     <= op_a_q >> CHUNKSIZE;
              op_b_q     <= op_b_q >> CHUNKSIZE;
              ccx_rs_a_o <= op_a_q[2*CHUNKSIZE-1:CHUNKSIZE];
              ccx_rs_b_o <= op_b_q[2*CHUNKSIZE-1:CHUNKSIZE];
              state_q    <= StSetup;
            end
          end else if (tmo_q == LastTmo) begin
            rdy_o   <= 1'b1;
            err_o   <= 1'b1;
            res_o   <= '0;
            state_q <= StDone;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StDone: begin
          busy_o  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccx_seq.sv
// Directed and random checks of ccx_seq against an external pad responder model.
module tb_ccx_seq;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_in = 1'b0;
  logic [1:0]  sel_in = '0;
  logic [31:0] rs_a = '0;
  logic [31:0] rs_b = '0;
  logic        busy, rdy, err;
  logic [31:0] res;
  logic [3:0]  cx_a, cx_b;
  logic [1:0]  cx_sel;
  logic        cx_req;
  logic [3:0]  res_ext = '0;
  logic        resp_ext = 1'b0;

  int   vectors = 0;
  int   miscompares = 0;
  int   resp_mode = 0;  // 0 normal, 1 silent, 2 stuck high
  int   max_dly = 0;
  int   wait_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ccx_seq u_dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req_in),
    .sel_i     (sel_in),
    .rs_a_i    (rs_a),
    .rs_b_i    (rs_b),
    .busy_o    (busy),
    .rdy_o     (rdy),
    .err_o     (err),
    .res_o     (res),
    .ccx_rs_a_o(cx_a),
    .ccx_rs_b_o(cx_b),
    .ccx_sel_o (cx_sel),
    .ccx_req_o (cx_req),
    .ccx_res_i (res_ext),
    .ccx_resp_i(resp_ext)
  );

  // Registered responder; each phase change waits a random 0..max_dly extra cycles.
  always @(posedge clk) begin
    case (resp_mode)
      1: resp_ext <= 1'b0;
      2: resp_ext <= 1'b1;
      default: begin
        if (cx_req != resp_ext) begin
          if (wait_cnt == 0) begin
            resp_ext <= cx_req;
            if (cx_req) res_ext <= cx_a ^ cx_b;
            wait_cnt <= $urandom_range(0, max_dly);
          end else begin
            wait_cnt <= wait_cnt - 1;
          end
        end
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one operation from a negedge; n counts negedges after the accept edge (cycle c+n).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                        input logic exp_err, input bit poke_busy, output int lat,
                        output int first_req, output int last_req, output int n_chg);
    exp_t       e;
    exp_t       got;
    int         n;
    int         k;
    int         idx;
    bit         done;
    logic       prev_req;
    logic [7:0] prev_chunk;
    e.res = exp_err ? 32'h0 : (a ^ b);
    e.err = exp_err;
    sb.push_back(e);
    rs_a = a;
    rs_b = b;
    sel_in = sel;
    req_in = 1'b1;
    @(posedge clk);
    n = 0; k = 0; done = 0; lat = -1; first_req = -1; last_req = -1; n_chg = 0;
    prev_req = 1'b0; prev_chunk = '0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        req_in = 1'b0;
        rs_a = ~a;
        rs_b = $urandom;
        sel_in = ~sel;
      end else if (poke_busy) begin
        req_in = ($urandom_range(0, 3) == 0);
      end
      check("sel_held", {30'h0, cx_sel}, {30'h0, sel});
      if (cx_req && !prev_req) k++;
      prev_req = cx_req;
      if (cx_req) begin
        if (first_req < 0) first_req = n;
        last_req = n;
        if (k >= 1 && k <= 8) begin
          idx = (k - 1) * 4;
          check("chunk_a", {28'h0, cx_a}, {28'h0, a[idx+:4]});
          check("chunk_b", {28'h0, cx_b}, {28'h0, b[idx+:4]});
        end else begin
          check("beat_overrun", k, 8);
        end
      end
      if (n > 1 && {cx_a, cx_b} != prev_chunk) n_chg++;
      prev_chunk = {cx_a, cx_b};
      if (rdy) begin
        done = 1;
        lat = n;
        req_in = 1'b0;
      end
    end
    if (!done) begin
      check("rdy_wait_expired", 0, 1);
      req_in = 1'b0;
    end else if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      got = sb.pop_front();
      check("res", res, got.res);
      check("err", {31'h0, err}, {31'h0, got.err});
      check("busy_at_done", {31'h0, busy}, 32'h1);
      if (!got.err) check("beats", k, 8);
    end
    @(negedge clk);
    check("busy_after", {31'h0, busy}, 32'h0);
    check("rdy_after", {31'h0, rdy}, 32'h0);
  endtask

  initial begin
    int lat, fr, lr, nc, k;
    logic prev_req;

    // Reset state
    @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_rdy", {31'h0, rdy}, 32'h0);
    check("rst_res", res, 32'h0);
    check("rst_req", {31'h0, cx_req}, 32'h0);
    check("rst_chunks", {24'h0, cx_a, cx_b}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Echo responder, latency and result
    run_op(32'h12345678, 32'hFFFF0000, 2'd1, 1'b0, 1'b0, lat, fr, lr, nc);
    check("echo_latency", lat, 73);
    check("echo_first_req", fr, 2);

    // Chunk ordering and stability
    run_op(32'h76543210, 32'h00000000, 2'd2, 1'b0, 1'b0, lat, fr, lr, nc);
    check("chunk_changes", nc, 7);

    // Silent responder -> timeout
    resp_mode = 1;
    run_op(32'hCAFEF00D, 32'h0BADBEEF, 2'd3, 1'b1, 1'b0, lat, fr, lr, nc);
    check("tmo_first_req", fr, 2);
    check("tmo_last_req", lr, 65);
    check("tmo_rdy_cycle", lat, 66);
    resp_mode = 0;
    repeat (4) @(negedge clk);

    // Stale ack blocks accept
    resp_mode = 2;
    repeat (4) @(negedge clk);
    req_in = 1'b1;
    @(negedge clk);
    req_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stale_no_accept", {31'h0, busy}, 32'h0);
    end
    resp_mode = 0;
    repeat (6) @(negedge clk);
    run_op(32'hA5A5A5A5, 32'h0F0F0F0F, 2'd0, 1'b0, 1'b0, lat, fr, lr, nc);
    check("post_stale_latency", lat, 73);

    // Random delays, random operands, req pulses while busy
    max_dly = 10;
    for (int i = 0; i < 200; i++) begin
      run_op($urandom, $urandom, 2'($urandom_range(0, 3)), 1'b0, 1'b1, lat, fr, lr, nc);
    end
    max_dly = 0;
    repeat (4) @(negedge clk);

    // Reset during beat 3
    rs_a = 32'h13579BDF;
    rs_b = 32'h2468ACE0;
    sel_in = 2'd3;
    req_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_in = 1'b0;
    k = 0;
    prev_req = 1'b0;
    for (int n = 0; n < 500 && !(k == 4 && cx_req); n++) begin
      @(negedge clk);
      if (cx_req && !prev_req) k++;
      prev_req = cx_req;
    end
    check("beat3_reached", k, 4);
    #1 rst = 1'b1;
    #1;
    check("arst_req", {31'h0, cx_req}, 32'h0);
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_rdy", {31'h0, rdy}, 32'h0);
    check("arst_chunks", {24'h0, cx_a, cx_b}, 32'h0);
    check("arst_sel", {30'h0, cx_sel}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    run_op(32'h89ABCDEF, 32'h01234567, 2'd2, 1'b0, 1'b0, lat, fr, lr, nc);
    check("post_rst_latency", lat, 73);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
